// File: rtl/weight_sched_pkg.sv
// -----------------------------------------------------------------------------
// weight_sched_pkg
// Shared types for the weight stream scheduler. It holds the default field
// widths of a layer descriptor, the packed descriptor layout (k_1 in the LSBs),
// the scheduler FSM state encoding, and the helper that builds the header beat
// sent to the rotator at the start of every iteration.
// -----------------------------------------------------------------------------
package weight_sched_pkg;

  localparam int BITS_K      = 4;
  localparam int BITS_CIN    = 10;
  localparam int BITS_COLS   = 9;
  localparam int BITS_BLOCKS = 8;
  localparam int BITS_CFG    = 4;
  localparam int BITS_ITR    = 10;

  // Full descriptor width and the width of the header payload
  localparam int DESC_W = BITS_K + BITS_CIN + BITS_COLS + BITS_BLOCKS + BITS_CFG + BITS_ITR;
  localparam int HDR_W  = BITS_K + BITS_CIN + BITS_COLS + BITS_BLOCKS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_CFG  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  // First member lands in the MSBs, so k_1 ends up at bit 0
  typedef struct packed {
    logic [BITS_ITR-1:0]    itr_1;
    logic [BITS_CFG-1:0]    cfg_beats_1;
    logic [BITS_BLOCKS-1:0] blocks_1;
    logic [BITS_COLS-1:0]   cols_1;
    logic [BITS_CIN-1:0]    cin_1;
    logic [BITS_K-1:0]      k_1;
  } desc_t;

  // Header payload as the rotator expects it: {blocks_1, cols_1, cin_1, k_1}
  function automatic logic [HDR_W-1:0] pack_header(input desc_t d);
    return {d.blocks_1, d.cols_1, d.cin_1, d.k_1};
  endfunction

endpackage

// File: rtl/weight_stream_scheduler.sv
// -----------------------------------------------------------------------------
// weight_stream_scheduler
// Frames the raw weight DMA stream for axis_weight_rotator. For each accepted
// layer descriptor it emits, ITR times: one generated header beat, then
// cfg_beats_1+1 config beats and (k_1+1)*(cin_1+1) weight beats passed straight
// through from the DMA, with m_axis_tlast on the last weight beat. Frame length
// comes from the descriptor counts; the DMA's tlast is only checked, never
// forwarded, and any misplaced or missing DMA tlast sets the sticky err_len.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_desc_*                 layer descriptor handshake (accepted in IDLE only)
//   s_raw_*                  raw weight stream from the DMA
//   m_axis_*                 framed stream to the rotator
//   busy                     FSM is not idle
//   done                     one-cycle pulse after the final beat of a layer
//   err_len                  sticky DMA tlast position error
// -----------------------------------------------------------------------------
module weight_stream_scheduler
  import weight_sched_pkg::*;
#(
  parameter int S_WEIGHTS_WIDTH_HF = 64,
  parameter int BITS_K             = weight_sched_pkg::BITS_K,
  parameter int BITS_CIN           = weight_sched_pkg::BITS_CIN,
  parameter int BITS_COLS          = weight_sched_pkg::BITS_COLS,
  parameter int BITS_BLOCKS        = weight_sched_pkg::BITS_BLOCKS,
  parameter int BITS_CFG           = weight_sched_pkg::BITS_CFG,
  parameter int BITS_ITR           = weight_sched_pkg::BITS_ITR
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_desc_tvalid,
  output logic                            s_desc_tready,
  input  logic [BITS_ITR+BITS_CFG+BITS_BLOCKS+BITS_COLS+BITS_CIN+BITS_K-1:0] s_desc_tdata,
  input  logic                            s_raw_tvalid,
  output logic                            s_raw_tready,
  input  logic [S_WEIGHTS_WIDTH_HF-1:0]   s_raw_tdata,
  input  logic [S_WEIGHTS_WIDTH_HF/8-1:0] s_raw_tkeep,
  input  logic                            s_raw_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [S_WEIGHTS_WIDTH_HF-1:0]   m_axis_tdata,
  output logic [S_WEIGHTS_WIDTH_HF/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done,
  output logic                            err_len
);

  localparam int DB_W  = BITS_K + BITS_CIN;
  localparam int PW    = DB_W + 2;
  localparam int CNT_W = (DB_W > BITS_CFG) ? DB_W : BITS_CFG;

  state_t            state_r, state_n;
  desc_t             desc_r;
  desc_t             desc_in_s;
  logic [DB_W-1:0]   data_beats_r;
  logic [DB_W-1:0]   data_beats_s;
  logic [PW-1:0]     k_ext_s, cin_ext_s, prod_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [BITS_ITR-1:0] itr_cnt_r;
  logic              done_r, err_len_r;
  logic              desc_fire_s, raw_xfer_s;
  logic              cfg_last_s, data_last_s, itr_last_s;
  logic [S_WEIGHTS_WIDTH_HF-1:0] hdr_data_s;

  assign desc_in_s   = desc_t'(s_desc_tdata);
  assign desc_fire_s = (state_r == ST_IDLE) && s_desc_tvalid;

  // Weight beats per iteration minus one; widened so (k+1)*(cin+1) never overflows
  assign k_ext_s      = PW'(desc_in_s.k_1) + PW'(1);
  assign cin_ext_s    = PW'(desc_in_s.cin_1) + PW'(1);
  assign prod_s       = k_ext_s * cin_ext_s;
  assign data_beats_s = DB_W'(prod_s - PW'(1));

  // A pass-through beat moves whenever the DMA and the rotator are both ready
  assign raw_xfer_s  = s_raw_tvalid && m_axis_tready;
  assign cfg_last_s  = (cnt_r == CNT_W'(desc_r.cfg_beats_1));
  assign data_last_s = (cnt_r == CNT_W'(data_beats_r));
  assign itr_last_s  = (itr_cnt_r == desc_r.itr_1);
  assign hdr_data_s  = S_WEIGHTS_WIDTH_HF'(pack_header(desc_r));

  assign busy    = (state_r != ST_IDLE);
  assign done    = done_r;
  assign err_len = err_len_r;

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and stream muxing; CFG/DATA are a combinational path DMA->rotator
  always_comb begin
    state_n       = state_r;
    s_desc_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_raw_tready  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_desc_tready = 1'b1;
        if (s_desc_tvalid) begin
          state_n = ST_HDR;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_data_s;
        m_axis_tkeep  = '1;
        if (m_axis_tready) begin
          state_n = ST_CFG;
        end else begin
          state_n = ST_HDR;
        end
      end
      ST_CFG: begin
        m_axis_tvalid = s_raw_tvalid;
        s_raw_tready  = m_axis_tready;
        m_axis_tdata  = s_raw_tdata;
        m_axis_tkeep  = s_raw_tkeep;
        if (raw_xfer_s && cfg_last_s) begin
          state_n = ST_DATA;
        end else begin
          state_n = ST_CFG;
        end
      end
      ST_DATA: begin
        m_axis_tvalid = s_raw_tvalid;
        s_raw_tready  = m_axis_tready;
        m_axis_tdata  = s_raw_tdata;
        m_axis_tkeep  = s_raw_tkeep;
        m_axis_tlast  = data_last_s;
        if (raw_xfer_s && data_last_s) begin
          if (itr_last_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_HDR;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Descriptor capture, including the precomputed weight beat count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      desc_r       <= '0;
      data_beats_r <= '0;
    end else if (desc_fire_s) begin
      desc_r       <= desc_in_s;
      data_beats_r <= data_beats_s;
    end
  end

  // Beat counter: restarts at each header accept and at each phase boundary
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= '0;
    end else if ((state_r == ST_HDR) && m_axis_tready) begin
      cnt_r <= '0;
    end else if ((state_r == ST_CFG) && raw_xfer_s) begin
      cnt_r <= cfg_last_s ? '0 : cnt_r + CNT_W'(1);
    end else if ((state_r == ST_DATA) && raw_xfer_s) begin
      cnt_r <= data_last_s ? '0 : cnt_r + CNT_W'(1);
    end
  end

  // Iteration counter: zeroed on descriptor accept, bumped at each non-final frame end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      itr_cnt_r <= '0;
    end else if (desc_fire_s) begin
      itr_cnt_r <= '0;
    end else if ((state_r == ST_DATA) && raw_xfer_s && data_last_s && !itr_last_s) begin
      itr_cnt_r <= itr_cnt_r + BITS_ITR'(1);
    end
  end

  // Layer completion pulse, one cycle after the final handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DATA) && raw_xfer_s && data_last_s && itr_last_s;
    end
  end

  // Sticky length error: DMA tlast must appear on the last weight beat and nowhere else
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_len_r <= 1'b0;
    end else if ((state_r == ST_CFG) && raw_xfer_s && s_raw_tlast) begin
      err_len_r <= 1'b1;
    end else if ((state_r == ST_DATA) && raw_xfer_s && (s_raw_tlast != data_last_s)) begin
      err_len_r <= 1'b1;
    end
  end

endmodule

// File: doc/weight_stream_scheduler.md
# weight_stream_scheduler

Sequences weight transfers into `axis_weight_rotator`. It accepts one layer descriptor at a time and emits a generated header beat. It then passes through the config beats and the K·CIN weight beats from the raw weight DMA stream, asserting `m_axis_tlast` at the end of each iteration. The whole frame repeats ITR times per layer. It sits between the weight DMA and the rotator's `s_axis_*` port and enforces the frame length the rotator expects.

## Interface
Parameters:
- `S_WEIGHTS_WIDTH_HF`, 64: stream data width in bits (multiple of 8, ≥ 32).
- `BITS_K`, 4: width of the `k_1` field.
- `BITS_CIN`, 10: width of the `cin_1` field.
- `BITS_COLS`, 9: width of the `cols_1` field.
- `BITS_BLOCKS`, 8: width of the `blocks_1` field.
- `BITS_CFG`, 4: width of the `cfg_beats_1` field.
- `BITS_ITR`, 10: width of the `itr_1` field.

Ports:
- `aclk`, in, 1: the only clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `s_desc_tvalid` / `s_desc_tready`, in / out, 1: descriptor handshake.
- `s_desc_tdata`, in, DESC_W: packed `{itr_1, cfg_beats_1, blocks_1, cols_1, cin_1, k_1}`, with `k_1` at the LSBs.
- `s_raw_tvalid` / `s_raw_tready`, in / out, 1: raw weight stream from the DMA.
- `s_raw_tdata`, in, S_WEIGHTS_WIDTH_HF.
- `s_raw_tkeep`, in, S_WEIGHTS_WIDTH_HF/8.
- `s_raw_tlast`, in, 1: the DMA marks the final beat of each iteration.
- `m_axis_tvalid` / `m_axis_tready`, out / in, 1: stream to the rotator.
- `m_axis_tdata`, out, S_WEIGHTS_WIDTH_HF.
- `m_axis_tkeep`, out, S_WEIGHTS_WIDTH_HF/8.
- `m_axis_tlast`, out, 1.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse after the last beat of the last iteration.
- `err_len`, out, 1: sticky flag for a raw `tlast` mismatch; cleared only by reset.

## Operation
- FSM states: IDLE → HDR → CFG → DATA → (HDR | IDLE).
- **IDLE**
  - `s_desc_tready` = 1.
  - On descriptor handshake: register all fields, set `itr_cnt` = 0, go to HDR.
  - Compute `data_beats_1` = (k_1+1)·(cin_1+1) − 1, registered, BITS_K+BITS_CIN bits, unsigned.
- **HDR**
  - `m_axis_tvalid` = 1.
  - `m_axis_tdata` = zero-extended `{blocks_1, cols_1, cin_1, k_1}`.
  - `m_axis_tkeep` = all ones; `m_axis_tlast` = 0; `s_raw_tready` = 0.
  - On `m_axis_tready`: clear the beat counter, go to CFG.
- **CFG**
  - Combinational pass-through: `m_axis_tvalid` = `s_raw_tvalid`, `s_raw_tready` = `m_axis_tready`, tdata/tkeep copied.
  - `m_axis_tlast` = 0.
  - After cfg_beats_1+1 transfers, clear the counter and go to DATA.
- **DATA**
  - Same pass-through as CFG.
  - `m_axis_tlast` = 1 on transfer number data_beats_1+1.
  - On that last transfer:
    - If `itr_cnt` == itr_1: pulse `done` the next cycle, go to IDLE.
    - Otherwise: increment `itr_cnt`, go to HDR.
- **Length check**
  - The expected raw `tlast` position is the last DATA beat only.
  - `s_raw_tlast` = 1 on any earlier beat (CFG or DATA), or `s_raw_tlast` = 0 on the last DATA beat, sets `err_len`.
  - The frame continues by count. Counts win and the DMA's `tlast` is never forwarded.
- **Boundaries**
  - `cfg_beats_1` = 0 → exactly one CFG beat.
  - `k_1` = `cin_1` = 0 → one DATA beat, which carries `tlast`.
  - `itr_1` = 0 → one iteration.
  - Counters compare for equality with the `_1` value. They never wrap past it.
- **Reset mid-frame**
  - All state is dropped immediately and the FSM returns to IDLE.
  - The downstream rotator is reset on the same `aresetn`.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `s_raw_tready`, `busy`, `done`, `err_len` = 0.
  - `m_axis_tdata`, `m_axis_tkeep` = 0.
  - `s_desc_tready` = 1 (state IDLE).
- Descriptor accept → header valid: 1 cycle (HDR entered on the next edge).
- CFG/DATA pass-through: zero latency, with no registers in the data path.
- `m_axis_tvalid` and the header data are held stable until accepted (AXIS rules).
- Header-to-header gap between iterations: 0 idle cycles (DATA→HDR on the same edge).
- `done` is asserted the cycle after the final handshake; `busy` falls on the same edge.
- Minimum layer length is 1 + (cfg_beats_1+1) + (data_beats_1+1) cycles per iteration under continuous valid/ready.

## Structure
- Package `weight_sched_pkg`:
  - State enum.
  - `desc_t` packed struct for the descriptor fields.
  - `DESC_W` and the header-packing function.
- No sub-modules required. The multiplier for `data_beats_1` is inferred inline and registered.

## Test plan
- **Single layer:** descriptor k_1=2, cin_1=2, cols_1=19, blocks_1=0, cfg_beats_1=1, itr_1=0; raw `tlast` on beat 11.
  - 12 output beats; header tdata = 0x4C022.
  - `tlast` only on beat 12; `done` 1 cycle later; `err_len` = 0.
- **Two iterations:** same descriptor with itr_1=1.
  - 24 beats; headers at beats 1 and 13; `tlast` at beats 12 and 24; single `done`.
- **Backpressure:** random `m_axis_tready` (50%) and random `s_raw_tvalid`.
  - Output sequence identical to the single-layer case; no beat dropped or duplicated; header held stable while stalled.
- **Length errors:**
  - Raw `tlast` on DATA beat 5 of 9 → `err_len` = 1, frame still 12 beats.
  - Separate run with raw `tlast` missing → `err_len` = 1.
- **Minimal frame:** k_1=cin_1=cfg_beats_1=itr_1=0 → 3 beats, `tlast` on beat 3.
- **Reset mid-DATA:** `aresetn` low at beat 7.
  - All outputs 0 at once; IDLE with `s_desc_tready` = 1 after release; the next descriptor runs cleanly.
